mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequential two-master arbiter sharing one memory port between requester 1 (instruction fetch) and
//  requester 2 (load/store). Replaces purely combinational port muxing with registered grant, latched
//  request, wait-state handshake (PREADY), timeout/error response and round-robin fairness.
//  Sits between the pipeline's fetch/LSU ports and the single-ported memory model/bus.
// PARAMETERS
//  AW           64   address width
//  DW           64   data width
//  ROUND_ROBIN  1    1: alternate on contention; 0: fixed priority, requester 1 always wins
//  TIMEOUT      255  max ACCESS cycles without PREADY before abort; 0 disables timeout
// PORTS
//  HCLK      in   1   clock, all state on rising edge
//  HRESET    in   1   reset, asynchronous, active-low
//  HTRANS_1  in   1   requester 1 request valid; held with HADDR/HWRITE/HWDATA stable until HREADY_1
//  HADDR_1   in   AW  requester 1 address
//  HWRITE_1  in   1   requester 1 write(1)/read(0)
//  HWDATA_1  in   DW  requester 1 write data
//  HRDATA_1  out  DW  requester 1 read data, valid with HREADY_1
//  HREADY_1  out  1   requester 1 completion, one-cycle pulse, registered
//  HRESP_1   out  1   requester 1 error (timeout), valid with HREADY_1
//  stall_1   out  1   HTRANS_1 & ~HREADY_1 (combinational)
//  HTRANS_2..stall_2  as above for requester 2
//  PSEL      out  1   memory access valid
//  PADDR     out  AW  memory address (latched)
//  PWRITE    out  1   memory write(1)/read(0)
//  PWDATA    out  DW  memory write data (latched)
//  PRDATA    in   DW  memory read data, sampled when PSEL & PREADY
//  PREADY    in   1   memory completes current access this cycle
// BEHAVIOUR
//  Reset: state IDLE; PSEL, PWRITE, HREADY_x, HRESP_x = 0; PADDR, PWDATA, HRDATA_x = 0; last_grant = 2.
//  States: IDLE, ACCESS.
//  IDLE: eligible_x = HTRANS_x & ~HREADY_x (completing master is masked for that cycle).
//   None eligible -> stay IDLE. One eligible -> grant it. Both -> ROUND_ROBIN=1: grant != last_grant;
//   ROUND_ROBIN=0: grant 1. On grant: latch HADDR/HWRITE/HWDATA into PADDR/PWRITE/PWDATA,
//   set owner and last_grant, clear timeout counter, PSEL<=1, -> ACCESS.
//  ACCESS: PSEL=1, PADDR/PWRITE/PWDATA held constant regardless of requester inputs.
//   PREADY=1 -> PSEL<=0, HREADY_owner<=1, HRESP_owner<=0, if read HRDATA_owner<=PRDATA, -> IDLE.
//   PREADY=0 & TIMEOUT!=0 & count==TIMEOUT-1 -> PSEL<=0, HREADY_owner<=1, HRESP_owner<=1,
//   HRDATA unchanged, -> IDLE. Else count++ (width $clog2(TIMEOUT+1), never wraps).
//  HREADY_x/HRESP_x: single-cycle pulses, cleared the following cycle. HRDATA_x holds until next read
//   completion for that master; write and error completions leave it unchanged.
//  Latency: request seen cycle n -> PSEL cycle n+1 -> PREADY in n+k -> HREADY pulse n+k+1. Min 2 cycles;
//   next grant decided in the same cycle as the HREADY pulse, so peak throughput is 1 access / 2 cycles.
//  Requester dropping HTRANS while in ACCESS: access still completes, HREADY pulse still issued.
//  PREADY while IDLE: ignored. Only one access outstanding at any time.
//  Async reset mid-ACCESS: PSEL drops immediately, no HREADY/HRESP pulse, access not retried.
// TESTING
//  1 Read M1: HTRANS_1=1 HADDR_1=0x1000 cyc0, PREADY=1 PRDATA=0xDEAD cyc1 -> PSEL/PADDR=0x1000 cyc1,
//    HREADY_1=1 HRDATA_1=0xDEAD HRESP_1=0 cyc2; stall_1=1 cyc0-1, 0 cyc2.
//  2 Contention RR: both HTRANS held, PREADY=1 always -> grants 1,2,1,2 after reset, PSEL every
//    other cycle; stall_2=1 while M1 served.
//  3 Wait states: M2 write 0x20 data 0x55, PREADY low 3 cycles -> PSEL 4 cycles, PADDR/PWDATA/PWRITE
//    stable despite input changes, one HREADY_2 pulse.
//  4 Timeout: TIMEOUT=4, PREADY=0 -> PSEL exactly 4 cycles, then HREADY_2=1 HRESP_2=1, HRDATA_2 unchanged.
//  5 Reset mid-ACCESS: HRESET=0 -> PSEL=0 same cycle, no HREADY; after release M1 and M2 both
//    request -> M1 granted first.
//  6 ROUND_ROBIN=0, both requesting continuously -> M1 granted every time, stall_2 stays 1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester buses (fetch=1, load/store=2) plus the shared memory port.
// slave = arbiter view, master = requester/memory-model view.
interface mem_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          HTRANS_1;
  logic [AW-1:0] HADDR_1;
  logic          HWRITE_1;
  logic [DW-1:0] HWDATA_1;
  logic [DW-1:0] HRDATA_1;
  logic          HREADY_1;
  logic          HRESP_1;
  logic          stall_1;

  logic          HTRANS_2;
  logic [AW-1:0] HADDR_2;
  logic          HWRITE_2;
  logic [DW-1:0] HWDATA_2;
  logic [DW-1:0] HRDATA_2;
  logic          HREADY_2;
  logic          HRESP_2;
  logic          stall_2;

  logic          PSEL;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  modport slave (
    input  HTRANS_1, HADDR_1, HWRITE_1, HWDATA_1,
    output HRDATA_1, HREADY_1, HRESP_1, stall_1,
    input  HTRANS_2, HADDR_2, HWRITE_2, HWDATA_2,
    output HRDATA_2, HREADY_2, HRESP_2, stall_2,
    output PSEL, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY
  );

  modport master (
    output HTRANS_1, HADDR_1, HWRITE_1, HWDATA_1,
    input  HRDATA_1, HREADY_1, HRESP_1, stall_1,
    output HTRANS_2, HADDR_2, HWRITE_2, HWDATA_2,
    input  HRDATA_2, HREADY_2, HRESP_2, stall_2,
    input  PSEL, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: registered two-master arbiter onto one memory port, with wait states and timeout.
// Ports: HCLK, HRESET (async, active-low), bus (mem_arbiter_if.slave: requesters 1/2 + memory).
module mem_arbiter #(
  parameter int AW          = 64,
  parameter int DW          = 64,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input logic          HCLK,
  input logic          HRESET,
  mem_arbiter_if.slave bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_n;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          psel, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          hready_1, hready_2;
  logic          hresp_1, hresp_2;
  logic [DW-1:0] hrdata_1, hrdata_2;
  logic          elig_1, elig_2;
  logic          grant, sel;
  logic          done, abort;

  // A master completing this cycle is masked so the other one gets a turn.
  assign elig_1 = bus.HTRANS_1 & ~hready_1;
  assign elig_2 = bus.HTRANS_2 & ~hready_2;

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    sel     = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (elig_1 | elig_2) begin
          grant   = 1'b1;
          state_n = ACCESS;
          unique case ({elig_1, elig_2})
            2'b11:   sel = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
            2'b01:   sel = 1'b1;
            default: sel = 1'b0;
          endcase
        end
      end
      ACCESS: begin
        if (bus.PREADY) begin
          done    = 1'b1;
          state_n = IDLE;
        end else if ((TIMEOUT != 0) && (cnt == CLAST)) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) state <= IDLE;
    else         state <= state_n;
  end

  // owner/last_grant: 0 = requester 1, 1 = requester 2.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      psel       <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      hready_1   <= 1'b0;
      hready_2   <= 1'b0;
      hresp_1    <= 1'b0;
      hresp_2    <= 1'b0;
      hrdata_1   <= '0;
      hrdata_2   <= '0;
    end else begin
      hready_1 <= 1'b0;
      hready_2 <= 1'b0;
      hresp_1  <= 1'b0;
      hresp_2  <= 1'b0;
      if (grant) begin
        psel       <= 1'b1;
        owner      <= sel;
        last_grant <= sel;
        cnt        <= '0;
        paddr      <= sel ? bus.HADDR_2  : bus.HADDR_1;
        pwrite     <= sel ? bus.HWRITE_2 : bus.HWRITE_1;
        pwdata     <= sel ? bus.HWDATA_2 : bus.HWDATA_1;
      end
      if (done | abort) begin
        psel <= 1'b0;
        if (owner) begin
          hready_2 <= 1'b1;
          hresp_2  <= abort;
          if (done & ~pwrite) hrdata_2 <= bus.PRDATA;
        end else begin
          hready_1 <= 1'b1;
          hresp_1  <= abort;
          if (done & ~pwrite) hrdata_1 <= bus.PRDATA;
        end
      end else if ((state == ACCESS) && (cnt != CMAX)) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.PSEL     = psel;
  assign bus.PADDR    = paddr;
  assign bus.PWRITE   = pwrite;
  assign bus.PWDATA   = pwdata;
  assign bus.HREADY_1 = hready_1;
  assign bus.HREADY_2 = hready_2;
  assign bus.HRESP_1  = hresp_1;
  assign bus.HRESP_2  = hresp_2;
  assign bus.HRDATA_1 = hrdata_1;
  assign bus.HRDATA_2 = hrdata_2;
  assign bus.stall_1  = bus.HTRANS_1 & ~hready_1;
  assign bus.stall_2  = bus.HTRANS_2 & ~hready_2;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for wait states,
// timeout, reset mid-access and fixed priority.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(64), .DW(64)) ia ();
  mem_arbiter_if #(.AW(64), .DW(64)) ib ();

  mem_arbiter #(.AW(64), .DW(64), .ROUND_ROBIN(1), .TIMEOUT(4)) dut_a (
    .HCLK(clk), .HRESET(rst_a), .bus(ia.slave)
  );
  mem_arbiter #(.AW(64), .DW(64), .ROUND_ROBIN(0), .TIMEOUT(0)) dut_b (
    .HCLK(clk), .HRESET(rst_b), .bus(ib.slave)
  );

  typedef struct {
    logic        t1;
    logic [63:0] a1;
    logic        t2;
    logic [63:0] a2;
    logic        pr;
    logic [63:0] prd;
    logic        psel;
    logic [63:0] paddr;
    logic        r1;
    logic        r2;
    logic [63:0] d1;
    logic [63:0] d2;
    logic        s1;
    logic        s2;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(
    input logic t1, input logic [63:0] a1,
    input logic t2, input logic [63:0] a2,
    input logic pr, input logic [63:0] prd,
    input logic psel, input logic [63:0] paddr,
    input logic r1, input logic r2,
    input logic [63:0] d1, input logic [63:0] d2,
    input logic s1, input logic s2);
    vec_t v;
    v.t1 = t1; v.a1 = a1; v.t2 = t2; v.a2 = a2;
    v.pr = pr; v.prd = prd; v.psel = psel; v.paddr = paddr;
    v.r1 = r1; v.r2 = r2; v.d1 = d1; v.d2 = d2;
    v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int npsel, nrdy, nrsp;

  initial begin
    ia.HTRANS_1 = 0; ia.HADDR_1 = 0; ia.HWRITE_1 = 0; ia.HWDATA_1 = 0;
    ia.HTRANS_2 = 0; ia.HADDR_2 = 0; ia.HWRITE_2 = 0; ia.HWDATA_2 = 0;
    ia.PRDATA = 0; ia.PREADY = 0;
    ib.HTRANS_1 = 0; ib.HADDR_1 = 0; ib.HWRITE_1 = 0; ib.HWDATA_1 = 0;
    ib.HTRANS_2 = 0; ib.HADDR_2 = 0; ib.HWRITE_2 = 0; ib.HWDATA_2 = 0;
    ib.PRDATA = 0; ib.PREADY = 0;
    rst_a = 0; rst_b = 0;

    // contention with round robin, then a single M1 read
    tbl[0]  = mk(1,'h100,1,'h200,1,'h0   ,0,'h0   ,0,0,'h0   ,'h0 ,1,1);
    tbl[1]  = mk(1,'h100,1,'h200,1,'hA1  ,1,'h100 ,0,0,'h0   ,'h0 ,1,1);
    tbl[2]  = mk(1,'h100,1,'h200,1,'h77  ,0,'h100 ,1,0,'hA1  ,'h0 ,0,1);
    tbl[3]  = mk(1,'h100,1,'h200,1,'hA2  ,1,'h200 ,0,0,'hA1  ,'h0 ,1,1);
    tbl[4]  = mk(1,'h100,1,'h200,1,'h77  ,0,'h200 ,0,1,'hA1  ,'hA2,1,0);
    tbl[5]  = mk(1,'h100,1,'h200,1,'hB1  ,1,'h100 ,0,0,'hA1  ,'hA2,1,1);
    tbl[6]  = mk(1,'h100,1,'h200,1,'h77  ,0,'h100 ,1,0,'hB1  ,'hA2,0,1);
    tbl[7]  = mk(0,'h100,0,'h200,1,'hB2  ,1,'h200 ,0,0,'hB1  ,'hA2,0,0);
    tbl[8]  = mk(0,'h100,0,'h200,0,'h0   ,0,'h200 ,0,1,'hB1  ,'hB2,0,0);
    tbl[9]  = mk(0,'h100,0,'h200,0,'h0   ,0,'h200 ,0,0,'hB1  ,'hB2,0,0);
    tbl[10] = mk(1,'h1000,0,'h0 ,0,'h0   ,0,'h200 ,0,0,'hB1  ,'hB2,1,0);
    tbl[11] = mk(1,'h1000,0,'h0 ,1,'hDEAD,1,'h1000,0,0,'hB1  ,'hB2,1,0);
    tbl[12] = mk(1,'h1000,0,'h0 ,0,'h0   ,0,'h1000,1,0,'hDEAD,'hB2,0,0);
    tbl[13] = mk(0,'h1000,0,'h0 ,1,'hBEEF,0,'h1000,0,0,'hDEAD,'hB2,0,0);
    tbl[14] = mk(0,'h1000,0,'h0 ,0,'h0   ,0,'h1000,0,0,'hDEAD,'hB2,0,0);

    tick();
    @(negedge clk);
    chk("rst psel",   ia.PSEL, 0);
    chk("rst paddr",  ia.PADDR, 0);
    chk("rst pwrite", ia.PWRITE, 0);
    chk("rst pwdata", ia.PWDATA, 0);
    chk("rst rdy",    {ia.HREADY_1, ia.HREADY_2, ia.HRESP_1, ia.HRESP_2}, 0);
    chk("rst rdata1", ia.HRDATA_1, 0);
    chk("rst rdata2", ia.HRDATA_2, 0);
    tick();
    rst_a = 1; rst_b = 1;

    for (int i = 0; i < 15; i++) begin
      ia.HTRANS_1 = tbl[i].t1; ia.HADDR_1 = tbl[i].a1;
      ia.HTRANS_2 = tbl[i].t2; ia.HADDR_2 = tbl[i].a2;
      ia.PREADY = tbl[i].pr; ia.PRDATA = tbl[i].prd;
      @(negedge clk);
      chk($sformatf("v%0d psel", i),   ia.PSEL, tbl[i].psel);
      chk($sformatf("v%0d paddr", i),  ia.PADDR, tbl[i].paddr);
      chk($sformatf("v%0d pwrite", i), ia.PWRITE, 0);
      chk($sformatf("v%0d rdy1", i),   ia.HREADY_1, tbl[i].r1);
      chk($sformatf("v%0d rdy2", i),   ia.HREADY_2, tbl[i].r2);
      chk($sformatf("v%0d resp", i),   {ia.HRESP_1, ia.HRESP_2}, 0);
      chk($sformatf("v%0d rdata1", i), ia.HRDATA_1, tbl[i].d1);
      chk($sformatf("v%0d rdata2", i), ia.HRDATA_2, tbl[i].d2);
      chk($sformatf("v%0d stall1", i), ia.stall_1, tbl[i].s1);
      chk($sformatf("v%0d stall2", i), ia.stall_2, tbl[i].s2);
      tick();
    end

    // M2 write with three wait states; inputs change during access
    npsel = 0; nrdy = 0;
    for (int c = 0; c < 8; c++) begin
      ia.HTRANS_1 = 0; ia.PREADY = (c == 4); ia.PRDATA = 'h99;
      if (c == 0) begin
        ia.HTRANS_2 = 1; ia.HADDR_2 = 'h20; ia.HWRITE_2 = 1; ia.HWDATA_2 = 'h55;
      end else if (c == 1) begin
        ia.HADDR_2 = 'hFF; ia.HWRITE_2 = 0; ia.HWDATA_2 = 'hAA;
      end else if (c >= 5) begin
        ia.HTRANS_2 = 0;
      end
      @(negedge clk);
      if (ia.PSEL) begin
        npsel++;
        chk("ws paddr",  ia.PADDR, 'h20);
        chk("ws pwdata", ia.PWDATA, 'h55);
        chk("ws pwrite", ia.PWRITE, 1);
      end
      if (ia.HREADY_2) begin
        nrdy++;
        chk("ws cycle", c, 5);
        chk("ws resp",  ia.HRESP_2, 0);
        chk("ws rdata", ia.HRDATA_2, 'hB2);
      end
      tick();
    end
    chk("ws psel cycles", npsel, 4);
    chk("ws pulses", nrdy, 1);

    // timeout: PREADY never comes
    npsel = 0; nrdy = 0;
    for (int c = 0; c < 9; c++) begin
      ia.PREADY = 0; ia.PRDATA = 'hBAD;
      ia.HTRANS_2 = (c <= 5); ia.HADDR_2 = 'h30; ia.HWRITE_2 = 0;
      @(negedge clk);
      if (ia.PSEL) npsel++;
      if (ia.HREADY_2) begin
        nrdy++;
        chk("to cycle", c, 5);
        chk("to resp",  ia.HRESP_2, 1);
        chk("to rdata", ia.HRDATA_2, 'hB2);
      end
      tick();
    end
    chk("to psel cycles", npsel, 4);
    chk("to pulses", nrdy, 1);

    // reset mid-access of M1, then both request
    ia.HTRANS_1 = 1; ia.HADDR_1 = 'h40; ia.HTRANS_2 = 0;
    tick();
    @(negedge clk);
    chk("rm psel before", ia.PSEL, 1);
    #2;
    rst_a = 0; ia.HTRANS_1 = 0;
    #1;
    chk("rm psel drop", ia.PSEL, 0);
    nrdy = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) rst_a = 1;
      @(negedge clk);
      if (ia.HREADY_1 || ia.HREADY_2) nrdy++;
      tick();
    end
    chk("rm no pulse", nrdy, 0);
    ia.HTRANS_1 = 1; ia.HADDR_1 = 'h50;
    ia.HTRANS_2 = 1; ia.HADDR_2 = 'h60;
    ia.PREADY = 1; ia.PRDATA = 'hC1;
    tick();
    @(negedge clk);
    chk("rm first paddr", ia.PADDR, 'h50);
    chk("rm first psel", ia.PSEL, 1);
    tick();
    ia.HTRANS_1 = 0; ia.HTRANS_2 = 0; ia.PREADY = 0;
    @(negedge clk);
    chk("rm rdy1", ia.HREADY_1, 1);
    chk("rm rdata1", ia.HRDATA_1, 'hC1);
    tick();

    // fixed priority: M1 wins every simultaneous request
    for (int r = 0; r < 3; r++) begin
      ib.HTRANS_1 = 1; ib.HADDR_1 = 64'h700 + 64'(r);
      ib.HTRANS_2 = 1; ib.HADDR_2 = 'h800;
      ib.PREADY = 1; ib.PRDATA = 64'hE0 + 64'(r);
      @(negedge clk);
      chk($sformatf("fp%0d stall2 c0", r), ib.stall_2, 1);
      tick();
      @(negedge clk);
      chk($sformatf("fp%0d paddr", r), ib.PADDR, 64'h700 + 64'(r));
      chk($sformatf("fp%0d stall2 c1", r), ib.stall_2, 1);
      tick();
      ib.HTRANS_1 = 0; ib.HTRANS_2 = 0; ib.PREADY = 0;
      @(negedge clk);
      chk($sformatf("fp%0d rdy", r), {ib.HREADY_1, ib.HREADY_2}, 2'b10);
      chk($sformatf("fp%0d rdata", r), ib.HRDATA_1, 64'hE0 + 64'(r));
      tick();
      @(negedge clk);
      chk($sformatf("fp%0d idle", r), ib.PSEL, 0);
      tick();
    end

    // timeout disabled: long wait completes normally
    npsel = 0; nrdy = 0; nrsp = 0;
    ib.HTRANS_2 = 1; ib.HADDR_2 = 'h900; ib.PRDATA = 'hF00D;
    for (int c = 0; c < 305; c++) begin
      ib.PREADY = (c == 300);
      if (c >= 302) ib.HTRANS_2 = 0;
      @(negedge clk);
      if (ib.PSEL) npsel++;
      if (ib.HREADY_2) begin
        nrdy++;
        if (ib.HRESP_2) nrsp++;
      end
      tick();
    end
    chk("nt psel cycles", npsel, 300);
    chk("nt pulses", nrdy, 1);
    chk("nt resp", nrsp, 0);
    chk("nt rdata", ib.HRDATA_2, 'hF00D);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
